instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, instruction-memory handshake and the IF/ID register.
// Misaligned redirect targets park the stage in HALT until reset.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oIMemReq,
    output logic [31:0] oIMemAddr,
    input  logic        iIMemReady,
    input  logic [31:0] iIMemData,
    input  logic        iStall,
    input  logic        iRedirect,
    input  logic [31:0] iRedirectPC,
    output logic [31:0] oInstruction,
    output logic [31:0] oPC,
    output logic [31:0] oPCPlus4,
    output logic        oValid,
    output logic        oMisaligned
);

    typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        valid_q, valid_d;
    logic        misaligned_q, misaligned_d;
    logic        req;
    logic        xfer;
    logic        consume;

    always_comb begin
        req     = (state_q == StFetch) && !(valid_q && iStall) && !iRedirect;
        xfer    = req && iIMemReady;
        consume = valid_q && !iStall;
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;
        unique case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                // Redirect outranks both the stall hold and any data returned this cycle.
                if (iRedirect) begin
                    pc_d    = iRedirectPC;
                    valid_d = 1'b0;
                    if (iRedirectPC[1:0] != 2'b00) begin
                        state_d      = StHalt;
                        misaligned_d = 1'b1;
                    end
                end else if (xfer) begin
                    instr_d  = iIMemData;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_q + 32'd4;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end
            StHalt: valid_d = 1'b0;
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            id_pc_q      <= 32'd0;
            id_pc4_q     <= 32'd4;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    always_comb begin
        oIMemReq     = req;
        oIMemAddr    = pc_q;
        oInstruction = valid_q ? instr_q : NOP_INSTR;
        oPC          = id_pc_q;
        oPCPlus4     = id_pc4_q;
        oValid       = valid_q;
        oMisaligned  = misaligned_q;
    end

endmodule
